// File: rtl/addsub_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arb_pkg
//  Description : Shared types and constants for the round-robin add/subtract
//                arbiter. Provides the controller state encoding and the
//                request op-bit meanings.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_arb_pkg;

    // Controller states for the shared datapath sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Meaning of the per-requester op bit.
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage : addsub_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. The search starts
//                one position after last_grant and wraps modulo NUM_REQ; the
//                first asserted request wins.
//  Ports       : req        - request vector (NUM_REQ)
//                last_grant - index of the most recently served requester
//                grant      - one-hot winner (all zero when no request)
//                grant_idx  - winner index (0 when no request)
//                grant_any  - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // k = NUM_REQ lands back on last_grant itself, so it has the lowest
        // priority and is only chosen when it is the sole requester.
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDW'(idx);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter
//  Description : Round-robin controller sharing one registered add/subtract
//                datapath among NUM_REQ requesters. A request is accepted in
//                IDLE, computed in EXEC and presented in RESP until the
//                consumer takes it. Results are tagged with the requester id.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                req_valid/req_ready      - per-requester handshake
//                req_op                   - 1 = add, 0 = subtract
//                req_a/req_b              - packed operands, WIDTH per requester
//                rsp_valid/rsp_ready      - response handshake
//                rsp_id                   - requester index of the response
//                rsp_result               - result modulo 2^WIDTH
//                rsp_carry                - carry-out (add) / borrow (subtract)
//  Options     : ADDSUB_ARB_SVA_EN - compiles protocol, latency and fairness
//                assertions together with their shadow registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,     // at least 2
    parameter  int WIDTH   = 8,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_carry
);

    state_t           r_state;
    logic [IDW-1:0]   r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic [IDW-1:0]   r_id;

    logic [WIDTH-1:0] w_a [NUM_REQ];
    logic [WIDTH-1:0] w_b [NUM_REQ];

    logic [NUM_REQ-1:0] w_grant;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_grant_any;
    logic               w_idle;
    logic               w_accept;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic               w_sel_op;
    logic [WIDTH:0]     w_alu;

    // Split the packed operand buses into per-requester words.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_a[i] = req_a[i*WIDTH +: WIDTH];
            assign w_b[i] = req_b[i*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .grant_any  (w_grant_any)
    );

    // Ready is offered only in IDLE, and never while reset is held so that
    // nothing can be accepted on a reset edge.
    assign w_idle    = (r_state == IDLE) && !rst;
    assign req_ready = w_idle ? w_grant : '0;
    assign w_accept  = w_idle && w_grant_any;

    assign w_sel_a   = w_a[w_grant_idx];
    assign w_sel_b   = w_b[w_grant_idx];
    assign w_sel_op  = req_op[w_grant_idx];

    // WIDTH+1-bit arithmetic: the top bit is the carry for add and the
    // borrow (a < b, unsigned) for subtract.
    assign w_alu = (r_op == OP_ADD) ? ({1'b0, r_a} + {1'b0, r_b})
                                    : ({1'b0, r_a} - {1'b0, r_b});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_id         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_any) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_id    <= w_grant_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    {rsp_carry, rsp_result} <= w_alu;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        r_last_grant <= rsp_id;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADDSUB_ARB_SVA_EN
    logic [WIDTH:0] w_sva_expect;
    assign w_sva_expect = (w_sel_op == OP_SUB) ? ({1'b0, w_sel_a} - {1'b0, w_sel_b})
                                               : ({1'b0, w_sel_a} + {1'b0, w_sel_b});

    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));

    a_ready_needs_valid : assert property (@(posedge clk) disable iff (rst)
        (req_ready & ~req_valid) == '0);

    a_rsp_stable : assert property (@(posedge clk) disable iff (rst)
        (rsp_valid && !rsp_ready) |=>
            (rsp_valid && $stable(rsp_id) && $stable(rsp_result) && $stable(rsp_carry)));

    a_latency_result : assert property (@(posedge clk) disable iff (rst)
        w_accept |-> ##2 (rsp_valid && rsp_id == $past(w_grant_idx, 2)
                          && {rsp_carry, rsp_result} == $past(w_sva_expect, 2)));

    // Count grants handed to others while a requester keeps waiting.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_fair
            logic [IDW:0] r_sva_wait;
            always_ff @(posedge clk) begin
                if (rst || !req_valid[i] || req_ready[i]) begin
                    r_sva_wait <= '0;
                end else if (w_accept) begin
                    r_sva_wait <= r_sva_wait + 1'b1;
                end
            end
            a_fair : assert property (@(posedge clk) disable iff (rst)
                r_sva_wait < (IDW+1)'(NUM_REQ));
        end
    endgenerate
`endif

endmodule : addsub_arbiter
`default_nettype wire

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin controller that shares one registered add/subtract datapath between NUM_REQ requesters.
- Each requester presents operands and an op bit through a valid/ready handshake.
- The block grants one requester, sequences the operation through the datapath, and returns the result tagged with the requester ID on a single response channel with backpressure.
- Sits between multiple client blocks and the shared arithmetic unit.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- WIDTH, 8: operand and result width in bits.
- IDW, $clog2(NUM_REQ): requester ID width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  NUM_REQ  per-requester op: 1 = add, 0 = subtract.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  index of the requester this response belongs to.
- rsp_result  output  WIDTH  result, modulo 2^WIDTH.
- rsp_carry  output  1  add: carry-out; subtract: borrow (1 when a < b, unsigned).

Behaviour:
- FSM states:
  - IDLE: if any req_valid, pick the winner g, assert req_ready[g] combinationally in the same cycle, latch a/b/op/id; go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute {carry,result} = a + b or a - b (WIDTH+1-bit arithmetic), register into the response registers, set rsp_valid; go to RESP.
  - RESP: hold rsp_valid and all rsp_* stable until rsp_ready. On the handshake, clear rsp_valid, set last_grant = rsp_id, go to IDLE.
- Arbitration: round-robin. Search starts at last_grant+1 and wraps modulo NUM_REQ. Only one req_ready bit may be high per cycle, and only in IDLE.
- req_ready is a combinational function of state, req_valid and last_grant. It must never be asserted without the matching req_valid.
- Latency: accept at cycle T; rsp_valid rises at T+2. With rsp_ready held high, the next accept can happen at T+3, so peak throughput is one op per 3 cycles.
- Operands are captured only at accept. Requester inputs may change freely afterwards.
- Reset:
  - State = IDLE, rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_id = 0, req_ready = 0.
  - last_grant = NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all reset values apply the next cycle.
- Boundaries:
  - Wrap-around: 8'hFF + 8'h01 gives result 8'h00, carry 1.
  - Underflow: 8'h00 - 8'h01 gives result 8'hFF, borrow 1.
  - A requester dropping req_valid before being granted is legal and causes no grant.
  - A requester holding req_valid while its earlier response is still in RESP is not accepted until the FSM returns to IDLE.
- rsp_ready while rsp_valid = 0 is ignored.

Optional Feature:
- Macro ADDSUB_ARB_SVA_EN.
- When defined, the module compiles concurrent assertions clocked on posedge clk and disabled during rst:
  - req_ready is onehot0.
  - req_ready[i] implies req_valid[i].
  - rsp_valid && !rsp_ready implies rsp_valid, rsp_id, rsp_result and rsp_carry stable at the next cycle.
  - An accept for id k implies ##2 rsp_valid with rsp_id == k and rsp_result equal to the captured operands' sum or difference.
  - Fairness: a requester holding req_valid is granted within NUM_REQ grants.
- When undefined: no assertions or auxiliary shadow registers; RTL behaviour is identical.

Decomposition:
- Package addsub_arb_pkg:
  - State enum (IDLE, EXEC, RESP), 2 bits.
  - Op constants OP_ADD = 1'b1, OP_SUB = 1'b0.
- One natural sub-module, rr_arbiter: pure combinational round-robin pick. Inputs: request vector and last_grant. Outputs: one-hot grant and grant index.
- Datapath stays inline.

Test Plan:
- Single add: rst for 2 cycles, then req0 with a = 8'd3, b = 8'd5, op = 1, rsp_ready = 1 -> req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_id = 0, result = 8'd8, carry = 0.
- Wrap/borrow: req1 add 8'hFF + 8'h01 -> result 8'h00, carry 1. Then req1 sub 8'h00 - 8'h01 -> result 8'hFF, carry 1.
- Round-robin: all 4 requesters valid continuously -> grant order 0, 1, 2, 3, 0; no requester granted twice before the others.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_* held stable, no req_ready asserted; rsp_ready = 1 -> handshake, IDLE next cycle.
- Reset mid-op: assert rst in EXEC -> next cycle rsp_valid = 0 and state IDLE; then req2 and req3 both valid -> req0 priority is restored, so req2 wins first.
- With ADDSUB_ARB_SVA_EN defined, run all scenarios above -> zero assertion failures; the formal run proves every assertion.
